// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: dbus-priority single-beat arbiter with ibus anti-starvation and response watchdog.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ibus_req_i,
    input  logic [ADDR_W-1:0]   ibus_addr_i,
    output logic [DATA_W-1:0]   ibus_data_o,
    output logic                ibus_ack_o,
    output logic                ibus_err_o,
    input  logic                dbus_req_i,
    input  logic                dbus_we_i,
    input  logic [ADDR_W-1:0]   dbus_addr_i,
    input  logic [DATA_W-1:0]   dbus_data_i,
    input  logic [DATA_W/8-1:0] dbus_sel_i,
    output logic [DATA_W-1:0]   dbus_data_o,
    output logic                dbus_ack_o,
    output logic                dbus_err_o,
    output logic                busy_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
    localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_d;
    logic                owner, owner_d;          // 1 = dbus owns the port
    logic [SC_W-1:0]     starve_cnt, starve_cnt_d;
    logic [7:0]          to_cnt, to_cnt_d;
    logic                mem_req_d, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [SEL_W-1:0]    mem_sel_d;
    logic [DATA_W-1:0]   ibus_data_d, dbus_data_d;
    logic                ibus_ack_d, dbus_ack_d, ibus_err_d, dbus_err_d, busy_d;
    logic                grant_dbus;
    logic                resp_fire;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;

    // dbus wins unless ibus has already waited out STARVE_MAX dbus grants
    assign grant_dbus = dbus_req_i && !(ibus_req_i && (starve_cnt == STARVE_LIM));

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        starve_cnt_d = starve_cnt;
        to_cnt_d     = to_cnt;
        mem_req_d    = mem_req_o;
        mem_we_d     = mem_we_o;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        mem_sel_d    = mem_sel_o;
        ibus_data_d  = ibus_data_o;
        dbus_data_d  = dbus_data_o;
        ibus_err_d   = ibus_err_o;
        dbus_err_d   = dbus_err_o;
        ibus_ack_d   = 1'b0;
        dbus_ack_d   = 1'b0;
        resp_fire    = 1'b0;
        resp_data    = '0;
        resp_err     = 1'b0;

        case (state)
            IDLE: begin
                if (grant_dbus) begin
                    owner_d     = 1'b1;
                    mem_we_d    = dbus_we_i;
                    mem_addr_d  = dbus_addr_i;
                    mem_wdata_d = dbus_data_i;
                    mem_sel_d   = dbus_sel_i;
                    mem_req_d   = 1'b1;
                    to_cnt_d    = 8'd0;
                    state_d     = BUSY;
                    if (!ibus_req_i)
                        starve_cnt_d = '0;
                    else if (starve_cnt != STARVE_LIM)
                        starve_cnt_d = starve_cnt + SC_ONE;
                end else if (ibus_req_i) begin
                    owner_d      = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = ibus_addr_i;
                    mem_wdata_d  = '0;
                    mem_sel_d    = '1;
                    mem_req_d    = 1'b1;
                    to_cnt_d     = 8'd0;
                    starve_cnt_d = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (mem_rvalid_i) begin
                    resp_fire = 1'b1;
                    resp_data = mem_we_o ? '0 : mem_rdata_i;
                end else if (to_cnt == TO_LAST) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt + 8'd1;
                end
                if (resp_fire) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner) begin
                        dbus_data_d = resp_data;
                        dbus_err_d  = resp_err;
                        dbus_ack_d  = 1'b1;
                    end else begin
                        ibus_data_d = resp_data;
                        ibus_err_d  = resp_err;
                        ibus_ack_d  = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            starve_cnt  <= '0;
            to_cnt      <= 8'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_sel_o   <= '0;
            ibus_data_o <= '0;
            dbus_data_o <= '0;
            ibus_err_o  <= 1'b0;
            dbus_err_o  <= 1'b0;
            ibus_ack_o  <= 1'b0;
            dbus_ack_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            starve_cnt  <= starve_cnt_d;
            to_cnt      <= to_cnt_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            mem_sel_o   <= mem_sel_d;
            ibus_data_o <= ibus_data_d;
            dbus_data_o <= dbus_data_d;
            ibus_err_o  <= ibus_err_d;
            dbus_err_o  <= dbus_err_d;
            ibus_ack_o  <= ibus_ack_d;
            dbus_ack_o  <= dbus_ack_d;
            busy_o      <= busy_d;
        end
    end

endmodule
`default_nettype wire
